// File: rtl/ntt_pkg.sv
// Shared constants and types for the NTT sequencer.
// Pure declarations; no logic, no latency, no flow control.
package ntt_pkg;
    localparam int N            = 256;
    localparam int ADDR_W       = 8;
    localparam int TW_W         = 8;
    localparam int KYBER_LAYERS = 7;
    localparam int DIL_LAYERS   = 8;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} ntt_state_t;
    typedef logic [ADDR_W-1:0] addr_t;
endpackage

// File: rtl/ntt_addr_gen.sv
// Maps pair index p and layer length 2^shift to butterfly addresses and twiddle index.
// Purely combinational, zero latency; no backpressure.
module ntt_addr_gen
    import ntt_pkg::*;
(
    input  logic [6:0]      p_i,
    input  logic [2:0]      shift_i,
    input  logic            inverse_i,
    output addr_t           addr_a_o,
    output addr_t           addr_b_o,
    output logic [TW_W-1:0] tw_idx_o
);
    logic [7:0] len;
    logic [7:0] grp;
    logic [7:0] ofs;
    logic [7:0] base;

    always_comb begin
        len  = 8'd1 << shift_i;
        grp  = {1'b0, p_i} >> shift_i;
        ofs  = {1'b0, p_i} & (len - 8'd1);
        base = (grp << ({1'b0, shift_i} + 4'd1)) | ofs;
        // 255 >> s equals 256/len - 1, which keeps the inverse index in 8 bits
        tw_idx_o = inverse_i ? (8'd255 >> shift_i) - grp
                             : (8'd128 >> shift_i) + grp;
    end

    assign addr_a_o = base;
    assign addr_b_o = base + len;
endmodule

// File: rtl/ntt_ctrl.sv
// Butterfly sequencer for in-place NTT/INTT over a 256-entry RAM; optional cycles_o under NTT_CYCLE_CNT_EN.
// One butterfly per cycle; writes trail reads by RD_LAT; RD_LAT drain cycles between layers.
// No backpressure: start_i is only accepted in IDLE, ignored while busy or in DONE.
module ntt_ctrl
    import ntt_pkg::*;
#(
    parameter int RD_LAT = 1,
    parameter int CNT_W  = 16
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            scheme_i,
    input  logic            inverse_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            sel_red_o,
    output logic            sel_butterfly_o,
    output logic            rd_en_o,
    output addr_t           rd_addr_a_o,
    output addr_t           rd_addr_b_o,
    output logic [TW_W-1:0] tw_idx_o,
    output logic            wr_en_o,
    output addr_t           wr_addr_a_o,
    output addr_t           wr_addr_b_o
`ifdef NTT_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0] cycles_o
`endif
);
    localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

    ntt_state_t state_q;
    logic [6:0] p_q;
    logic [2:0] shift_q;
    logic [1:0] drain_q;
    logic       sel_red_q;
    logic       sel_bf_q;
    logic       run;
    logic       last_layer;
    addr_t      gen_a;
    addr_t      gen_b;
    logic [TW_W-1:0] gen_tw;

    logic  wr_en_sr_q [RD_LAT];
    addr_t wr_a_sr_q  [RD_LAT];
    addr_t wr_b_sr_q  [RD_LAT];

    assign run = (state_q == RUN);
    // Kyber stops at len 2 (shift 1), Dilithium at len 1 (shift 0)
    assign last_layer = sel_bf_q ? (shift_q == 3'd7) : (shift_q == {2'b00, sel_red_q});

    ntt_addr_gen u_addr_gen (
        .p_i       (p_q),
        .shift_i   (shift_q),
        .inverse_i (sel_bf_q),
        .addr_a_o  (gen_a),
        .addr_b_o  (gen_b),
        .tw_idx_o  (gen_tw)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            p_q       <= '0;
            shift_q   <= '0;
            drain_q   <= '0;
            sel_red_q <= 1'b0;
            sel_bf_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start_i) begin
                    sel_red_q <= scheme_i;
                    sel_bf_q  <= inverse_i;
                    shift_q   <= inverse_i ? {2'b00, scheme_i} : 3'd7;
                    p_q       <= '0;
                    state_q   <= RUN;
                end
                RUN: begin
                    p_q <= p_q + 7'd1;
                    if (p_q == 7'd127) begin
                        drain_q <= '0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    drain_q <= drain_q + 2'd1;
                    if (drain_q == DRAIN_LAST) begin
                        if (last_layer) begin
                            state_q <= DONE;
                        end else begin
                            shift_q <= sel_bf_q ? shift_q + 3'd1 : shift_q - 3'd1;
                            state_q <= RUN;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < RD_LAT; i++) begin
                wr_en_sr_q[i] <= 1'b0;
                wr_a_sr_q[i]  <= '0;
                wr_b_sr_q[i]  <= '0;
            end
        end else begin
            wr_en_sr_q[0] <= rd_en_o;
            wr_a_sr_q[0]  <= rd_addr_a_o;
            wr_b_sr_q[0]  <= rd_addr_b_o;
            for (int i = 1; i < RD_LAT; i++) begin
                wr_en_sr_q[i] <= wr_en_sr_q[i-1];
                wr_a_sr_q[i]  <= wr_a_sr_q[i-1];
                wr_b_sr_q[i]  <= wr_b_sr_q[i-1];
            end
        end
    end

    assign busy_o          = run || (state_q == DRAIN);
    assign done_o          = (state_q == DONE);
    assign sel_red_o       = sel_red_q;
    assign sel_butterfly_o = sel_bf_q;
    assign rd_en_o         = run;
    assign rd_addr_a_o     = run ? gen_a  : '0;
    assign rd_addr_b_o     = run ? gen_b  : '0;
    assign tw_idx_o        = run ? gen_tw : '0;
    assign wr_en_o         = wr_en_sr_q[RD_LAT-1];
    assign wr_addr_a_o     = wr_a_sr_q[RD_LAT-1];
    assign wr_addr_b_o     = wr_b_sr_q[RD_LAT-1];

`ifdef NTT_CYCLE_CNT_EN
    logic [CNT_W-1:0] cyc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cyc_q <= '0;
        end else if (state_q == IDLE && start_i) begin
            cyc_q <= '0;
        end else if (busy_o && cyc_q != '1) begin
            cyc_q <= cyc_q + 1'b1;
        end
    end

    assign cycles_o = cyc_q;
`endif
endmodule

// File: tb/tb_ntt_ctrl.sv
// Bench for ntt_ctrl: RD_LAT=1 and RD_LAT=3 instances run side by side against a trace model.
module tb_ntt_ctrl;
    import ntt_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic scheme;
    logic inverse;

    logic  busy [2];
    logic  done [2];
    logic  sred [2];
    logic  sbf  [2];
    logic  rden [2];
    logic  wren [2];
    addr_t ra   [2];
    addr_t rb   [2];
    addr_t wa   [2];
    addr_t wb   [2];
    logic [7:0] tw [2];
`ifdef NTT_CYCLE_CNT_EN
    logic [15:0] cyc [2];
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit esr = 1'b0;
    bit esb = 1'b0;

    always #5 clk = ~clk;

    ntt_ctrl #(.RD_LAT(1), .CNT_W(16)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .scheme_i(scheme), .inverse_i(inverse),
        .busy_o(busy[0]), .done_o(done[0]), .sel_red_o(sred[0]), .sel_butterfly_o(sbf[0]),
        .rd_en_o(rden[0]), .rd_addr_a_o(ra[0]), .rd_addr_b_o(rb[0]), .tw_idx_o(tw[0]),
        .wr_en_o(wren[0]), .wr_addr_a_o(wa[0]), .wr_addr_b_o(wb[0])
`ifdef NTT_CYCLE_CNT_EN
        , .cycles_o(cyc[0])
`endif
    );

    ntt_ctrl #(.RD_LAT(3), .CNT_W(16)) u_dut3 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .scheme_i(scheme), .inverse_i(inverse),
        .busy_o(busy[1]), .done_o(done[1]), .sel_red_o(sred[1]), .sel_butterfly_o(sbf[1]),
        .rd_en_o(rden[1]), .rd_addr_a_o(ra[1]), .rd_addr_b_o(rb[1]), .tw_idx_o(tw[1]),
        .wr_en_o(wren[1]), .wr_addr_a_o(wa[1]), .wr_addr_b_o(wb[1])
`ifdef NTT_CYCLE_CNT_EN
        , .cycles_o(cyc[1])
`endif
    );

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic int busy_len(input int r, input bit kyb);
        return (kyb ? 7 : 8) * (128 + r);
    endfunction

    // Read issued in busy cycle t (t=0 is the first busy cycle), from the layer schedule.
    function automatic void rd_model(input int t, input int r, input bit kyb, input bit inv,
                                     output bit en, output int a, output int b, output int w);
        int per, layer, p, len, g, j;
        per = 128 + r;
        en = 1'b0; a = 0; b = 0; w = 0;
        if (t < 0 || t >= busy_len(r, kyb)) return;
        layer = t / per;
        p     = t % per;
        if (p >= 128) return;
        len = inv ? ((kyb ? 2 : 1) << layer) : (128 >> layer);
        g = p / len;
        j = p % len;
        a = 2 * len * g + j;
        b = a + len;
        w = inv ? (256 / len - 1 - g) : (128 / len + g);
        en = 1'b1;
    endfunction

    function automatic logic [45:0] exp_vec(input int t, input int r, input bit kyb, input bit inv);
        bit e1, e2, bz, dn;
        int a1, b1, w1, a2, b2, w2;
        rd_model(t, r, kyb, inv, e1, a1, b1, w1);
        rd_model(t - r, r, kyb, inv, e2, a2, b2, w2);
        bz = (t >= 0) && (t < busy_len(r, kyb));
        dn = (t == busy_len(r, kyb));
        return {bz, dn, e1, a1[7:0], b1[7:0], w1[7:0], e2, a2[7:0], b2[7:0], esr, esb};
    endfunction

    function automatic logic [45:0] obs(input int k);
        return {busy[k], done[k], rden[k], ra[k], rb[k], tw[k], wren[k], wa[k], wb[k], sred[k], sbf[k]};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; scheme = 1'b0; inverse = 1'b0;
        esr = 1'b0; esb = 1'b0;
        #3;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs(k) !== exp_vec(-1, lat(k), 1'b1, 1'b0)) begin
                n_bad++;
                $display("FAIL reset dut%0d got=%h exp=%h", k, obs(k), exp_vec(-1, lat(k), 1'b1, 1'b0));
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs(k) !== exp_vec(-1, lat(k), 1'b1, 1'b0)) begin
                    n_bad++;
                    $display("FAIL idle dut%0d got=%h exp=%h", k, obs(k), exp_vec(-1, lat(k), 1'b1, 1'b0));
                end
            end
        end
    endtask

    // Runs one transform; abort_t >= 0 returns at that busy cycle's sample point.
    task automatic test_op(input bit kyb, input bit inv, input bit noise, input int abort_t);
        int nbusy [2];
        int ndone [2];
        int tend;
        nbusy = '{0, 0};
        ndone = '{0, 0};
        @(negedge clk);
        scheme = kyb; inverse = inv; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        esr = kyb; esb = inv;
        tend = busy_len(3, kyb) + 4;
        for (int t = 0; t <= tend; t++) begin
            if (t == abort_t) return;
            for (int k = 0; k < 2; k++) begin
                n_cmp++;
                if (obs(k) !== exp_vec(t, lat(k), kyb, inv)) begin
                    n_bad++;
                    $display("FAIL op t=%0d dut%0d got=%h exp=%h", t, k, obs(k), exp_vec(t, lat(k), kyb, inv));
                end
                nbusy[k] += int'(busy[k]);
                ndone[k] += int'(done[k]);
            end
            // stray starts only while both instances are still busy or in DONE
            start   = (noise && t < busy_len(1, kyb)) ? 1'($urandom_range(0, 1)) : 1'b0;
            scheme  = 1'($urandom_range(0, 1));
            inverse = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
        end
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (nbusy[k] != busy_len(lat(k), kyb)) begin
                n_bad++;
                $display("FAIL busy_len dut%0d got=%0d exp=%0d", k, nbusy[k], busy_len(lat(k), kyb));
            end
            n_cmp++;
            if (ndone[k] != 1) begin
                n_bad++;
                $display("FAIL done_pulses dut%0d got=%0d exp=1", k, ndone[k]);
            end
`ifdef NTT_CYCLE_CNT_EN
            n_cmp++;
            if (int'(cyc[k]) != busy_len(lat(k), kyb)) begin
                n_bad++;
                $display("FAIL cycles dut%0d got=%0d exp=%0d", k, cyc[k], busy_len(lat(k), kyb));
            end
`endif
        end
    endtask

    task automatic test_reset_mid();
        test_op(1'b1, 1'b0, 1'b1, 2 * 129 + 50);
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        esr = 1'b0; esb = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs(k) !== exp_vec(-1, lat(k), 1'b1, 1'b0)) begin
                n_bad++;
                $display("FAIL mid_reset dut%0d got=%h exp=%h", k, obs(k), exp_vec(-1, lat(k), 1'b1, 1'b0));
            end
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        test_idle(12);
    endtask

    initial begin
        test_reset();
        test_idle(3);
        test_op(1'b1, 1'b0, 1'b0, -1);
        test_idle(2);
        test_op(1'b0, 1'b0, 1'b1, -1);
        test_op(1'b1, 1'b1, 1'b1, -1);
        test_op(1'b0, 1'b1, 1'b1, -1);
        test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            test_idle($urandom_range(1, 5));
            test_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1, -1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
